// File: rtl/decoder_pkg.sv
// Shared types and constants for the scanning one-hot decoder.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_scan_nx2n_onehot_dec.sv
// Combinational binary to one-hot decoder.
module onehot_dec #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]    sel,
    output logic [2**SEL_W-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/decoder_scan_nx2n.sv
// Registered one-hot decoder with DIRECT select and auto-stepping SCAN modes.
module decoder_scan_nx2n #(
    parameter int SEL_W      = 3,
    parameter int DWELL_W    = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel_in,
    input  logic                 load,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [2**SEL_W-1:0]  out,
    output logic [SEL_W-1:0]     idx,
    output logic                 out_valid,
    output logic                 wrap
);
    import decoder_pkg::*;

    localparam int OUT_W = 2**SEL_W;
    localparam logic [OUT_W-1:0] IDLE_OUT = {OUT_W{ACTIVE_LOW}};

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   idx_nxt;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_nxt;
    logic [DWELL_W-1:0] dwell_reg;
    logic               valid_nxt;
    logic               wrap_nxt;
    logic [OUT_W-1:0]   onehot;

    // Decoding the next index lets out and idx update on the same edge.
    onehot_dec #(.SEL_W(SEL_W)) u_dec (
        .sel    (idx_nxt),
        .onehot (onehot)
    );

    always_comb begin
        state_nxt = IDLE;
        idx_nxt   = idx;
        cnt_nxt   = '0;
        valid_nxt = 1'b0;
        wrap_nxt  = 1'b0;
        if (en) begin
            valid_nxt = 1'b1;
            case (mode)
                MODE_DIRECT: begin
                    state_nxt = DIRECT;
                    idx_nxt   = sel_in;
                end
                MODE_SCAN: begin
                    state_nxt = SCAN;
                    // Entry restarts at 0; a load strobe resets the dwell and blocks the advance.
                    if (state != SCAN) begin
                        idx_nxt = '0;
                    end else if (load) begin
                        idx_nxt = idx;
                    end else if (cnt == dwell_reg) begin
                        idx_nxt  = idx + SEL_W'(1);
                        wrap_nxt = &idx;
                    end else begin
                        cnt_nxt = cnt + DWELL_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            dwell_reg <= '0;
            out       <= IDLE_OUT;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            out_valid <= valid_nxt;
            wrap      <= wrap_nxt;
            out       <= valid_nxt ? (onehot ^ IDLE_OUT) : IDLE_OUT;
            if (load) begin
                dwell_reg <= dwell;
            end
        end
    end

endmodule

// File: tb/tb_decoder_scan_nx2n.sv
// Directed bench for decoder_scan_nx2n: default 8-line instance plus a 4-line active-low instance.
module tb_decoder_scan_nx2n;

    logic       clk = 1'b0;
    logic       rst, en, mode, load;
    logic [2:0] sel_in;
    logic [1:0] sel2;
    logic [7:0] dwell;

    logic [7:0] out;
    logic [2:0] idx;
    logic       out_valid, wrap;
    logic [3:0] out2;
    logic [1:0] idx2;
    logic       valid2, wrap2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decoder_scan_nx2n dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .sel_in    (sel_in),
        .load      (load),
        .dwell     (dwell),
        .out       (out),
        .idx       (idx),
        .out_valid (out_valid),
        .wrap      (wrap)
    );

    decoder_scan_nx2n #(.SEL_W(2), .DWELL_W(8), .ACTIVE_LOW(1'b1)) dut_al (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .sel_in    (sel2),
        .load      (load),
        .dwell     (dwell),
        .out       (out2),
        .idx       (idx2),
        .out_valid (valid2),
        .wrap      (wrap2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; mode = 1'b1; load = 1'b0;
        dwell = 8'd0; sel_in = 3'd0; sel2 = 2'd0;
        tick; tick;
        n_checks++;
        if ({out, idx, out_valid, wrap} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got %h want %h", {out, idx, out_valid, wrap}, {8'h00, 3'd0, 1'b0, 1'b0});
        end
        n_checks++;
        if ({out2, valid2} !== {4'hF, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_al: got %h want %h", {out2, valid2}, {4'hF, 1'b0});
        end
        rst = 1'b0;
        tick;
        n_checks++;
        if ({out, idx, out_valid, wrap} !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL scan_start: got %h want %h", {out, idx, out_valid, wrap}, {8'h01, 3'd0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_direct;
        logic [7:0] exp_tab [8];
        exp_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sel_in = 3'(i);
            tick;
            n_checks++;
            if ({out, idx, out_valid, wrap} !== {exp_tab[i], 3'(i), 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL direct[%0d]: got %h want %h", i, {out, idx, out_valid, wrap}, {exp_tab[i], 3'(i), 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_scan_timing;
        logic [2:0] e_idx;
        logic       e_wrap;
        load = 1'b1; dwell = 8'd2;
        tick;
        load = 1'b0;
        n_checks++;
        if ({out, idx, out_valid, wrap} !== {8'h80, 3'd7, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL load_in_direct: got %h want %h", {out, idx, out_valid, wrap}, {8'h80, 3'd7, 1'b1, 1'b0});
        end
        mode = 1'b1;
        tick;
        n_checks++;
        if ({out, idx, out_valid, wrap} !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL scan_entry: got %h want %h", {out, idx, out_valid, wrap}, {8'h01, 3'd0, 1'b1, 1'b0});
        end
        // Each line held 3 cycles; the edge after 24 cycles wraps back to line 0.
        for (int c = 1; c <= 24; c++) begin
            tick;
            e_idx  = 3'((c / 3) % 8);
            e_wrap = (c == 24);
            n_checks++;
            if ({out, idx, out_valid, wrap} !== {8'h01 << e_idx, e_idx, 1'b1, e_wrap}) begin
                n_fail++;
                $display("FAIL scan_dwell2[%0d]: got %h want %h", c, {out, idx, out_valid, wrap}, {8'h01 << e_idx, e_idx, 1'b1, e_wrap});
            end
        end
    endtask

    task automatic test_dwell0;
        logic [2:0] e_idx;
        logic       e_wrap;
        load = 1'b1; dwell = 8'd0;
        tick;
        load = 1'b0;
        n_checks++;
        if ({out, idx, out_valid, wrap} !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL load_hold: got %h want %h", {out, idx, out_valid, wrap}, {8'h01, 3'd0, 1'b1, 1'b0});
        end
        for (int c = 1; c <= 16; c++) begin
            tick;
            e_idx  = 3'(c % 8);
            e_wrap = (c % 8 == 0);
            n_checks++;
            if ({out, idx, out_valid, wrap} !== {8'h01 << e_idx, e_idx, 1'b1, e_wrap}) begin
                n_fail++;
                $display("FAIL scan_dwell0[%0d]: got %h want %h", c, {out, idx, out_valid, wrap}, {8'h01 << e_idx, e_idx, 1'b1, e_wrap});
            end
        end
    endtask

    task automatic test_load_on_advance;
        // dwell_reg is 0 here, so this edge would advance without the load.
        load = 1'b1; dwell = 8'd1;
        tick;
        load = 1'b0;
        n_checks++;
        if ({out, idx} !== {8'h01, 3'd0}) begin
            n_fail++;
            $display("FAIL load_wins_0: got %h want %h", {out, idx}, {8'h01, 3'd0});
        end
        tick;
        n_checks++;
        if (idx !== 3'd0) begin
            n_fail++;
            $display("FAIL load_cnt_step: got %h want %h", idx, 3'd0);
        end
        tick;
        n_checks++;
        if ({out, idx} !== {8'h02, 3'd1}) begin
            n_fail++;
            $display("FAIL dwell1_adv: got %h want %h", {out, idx}, {8'h02, 3'd1});
        end
        tick;
        load = 1'b1;
        tick;
        load = 1'b0;
        n_checks++;
        if ({out, idx} !== {8'h02, 3'd1}) begin
            n_fail++;
            $display("FAIL load_wins_1: got %h want %h", {out, idx}, {8'h02, 3'd1});
        end
        tick;
        n_checks++;
        if ({out, idx} !== {8'h02, 3'd1}) begin
            n_fail++;
            $display("FAIL load_cnt_cleared: got %h want %h", {out, idx}, {8'h02, 3'd1});
        end
        tick;
        n_checks++;
        if ({out, idx, wrap} !== {8'h04, 3'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL post_load_adv: got %h want %h", {out, idx, wrap}, {8'h04, 3'd2, 1'b0});
        end
    endtask

    task automatic test_en_drop;
        en = 1'b0;
        tick;
        n_checks++;
        if ({out, idx, out_valid, wrap} !== {8'h00, 3'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_hold: got %h want %h", {out, idx, out_valid, wrap}, {8'h00, 3'd2, 1'b0, 1'b0});
        end
        load = 1'b1; dwell = 8'd0;
        tick;
        load = 1'b0;
        en = 1'b1;
        tick;
        n_checks++;
        if ({out, idx, out_valid, wrap} !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL scan_reentry: got %h want %h", {out, idx, out_valid, wrap}, {8'h01, 3'd0, 1'b1, 1'b0});
        end
        for (int c = 0; c < 5; c++) tick;
        n_checks++;
        if ({out, idx, out_valid} !== {8'h20, 3'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL idle_load_dwell0: got %h want %h", {out, idx, out_valid}, {8'h20, 3'd5, 1'b1});
        end
        en = 1'b0;
        tick;
        n_checks++;
        if ({out, idx, out_valid, wrap} !== {8'h00, 3'd5, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL en_drop: got %h want %h", {out, idx, out_valid, wrap}, {8'h00, 3'd5, 1'b0, 1'b0});
        end
        en = 1'b1;
        tick;
        n_checks++;
        if ({out, idx, out_valid, wrap} !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reenable: got %h want %h", {out, idx, out_valid, wrap}, {8'h01, 3'd0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_mode_switch;
        tick; tick; tick;
        n_checks++;
        if ({out, idx} !== {8'h08, 3'd3}) begin
            n_fail++;
            $display("FAIL pre_switch: got %h want %h", {out, idx}, {8'h08, 3'd3});
        end
        mode = 1'b0; sel_in = 3'd6;
        tick;
        n_checks++;
        if ({out, idx, out_valid, wrap} !== {8'h40, 3'd6, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL scan_to_direct: got %h want %h", {out, idx, out_valid, wrap}, {8'h40, 3'd6, 1'b1, 1'b0});
        end
        mode = 1'b1;
        tick;
        n_checks++;
        if ({out, idx, out_valid, wrap} !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL direct_to_scan: got %h want %h", {out, idx, out_valid, wrap}, {8'h01, 3'd0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_active_low;
        logic [3:0] exp_out [4];
        logic [1:0] exp_idx [4];
        logic       exp_wrap [4];
        exp_out  = '{4'hD, 4'hB, 4'h7, 4'hE};
        exp_idx  = '{2'd1, 2'd2, 2'd3, 2'd0};
        exp_wrap = '{1'b0, 1'b0, 1'b0, 1'b1};
        rst = 1'b1;
        tick;
        n_checks++;
        if ({out2, idx2, valid2, wrap2} !== {4'hF, 2'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL al_reset: got %h want %h", {out2, idx2, valid2, wrap2}, {4'hF, 2'd0, 1'b0, 1'b0});
        end
        rst = 1'b0; en = 1'b1; mode = 1'b1; load = 1'b1; dwell = 8'd0;
        tick;
        load = 1'b0;
        n_checks++;
        if ({out2, idx2, valid2, wrap2} !== {4'hE, 2'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL al_entry: got %h want %h", {out2, idx2, valid2, wrap2}, {4'hE, 2'd0, 1'b1, 1'b0});
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            n_checks++;
            if ({out2, idx2, valid2, wrap2} !== {exp_out[i], exp_idx[i], 1'b1, exp_wrap[i]}) begin
                n_fail++;
                $display("FAIL al_scan[%0d]: got %h want %h", i, {out2, idx2, valid2, wrap2}, {exp_out[i], exp_idx[i], 1'b1, exp_wrap[i]});
            end
        end
        mode = 1'b0; sel2 = 2'd2;
        tick;
        n_checks++;
        if ({out2, idx2, valid2, wrap2} !== {4'hB, 2'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL al_direct: got %h want %h", {out2, idx2, valid2, wrap2}, {4'hB, 2'd2, 1'b1, 1'b0});
        end
        en = 1'b0;
        tick;
        n_checks++;
        if ({out2, idx2, valid2, wrap2} !== {4'hF, 2'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL al_idle: got %h want %h", {out2, idx2, valid2, wrap2}, {4'hF, 2'd2, 1'b0, 1'b0});
        end
    endtask

    initial begin
        test_reset;
        test_direct;
        test_scan_timing;
        test_dwell0;
        test_load_on_advance;
        test_en_drop;
        test_mode_switch;
        test_active_low;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
